// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Instruction queue between fetch and decode. Holds {pc, instruction,
//   kanata id} entries in a DEPTH-entry circular array and presents the
//   oldest one to decode with first-word fall-through. ready_o acts as the
//   fetch stall and depends only on stored state, so decode backpressure
//   never combinationally reaches fetch. A taken branch (flush_i) empties
//   the queue in one cycle.
//
// Ports
//   clk_i        : clock, all state updates on the rising edge
//   rstn_i       : asynchronous active-low reset
//   flush_i      : taken branch / redirect, empties the buffer
//   valid_i      : fetch presents an instruction
//   pc_i         : PC of the presented instruction
//   instr_i      : presented instruction word
//   kanata_id_i  : trace id of the presented instruction
//   ready_o      : buffer can accept a push this cycle (fetch stall = ~ready_o)
//   valid_o      : head entry valid for decode
//   pc_o         : head PC (0 when empty)
//   instr_o      : head instruction (0 when empty)
//   kanata_id_o  : head trace id (0 when empty)
//   ready_i      : decode consumes the head this cycle
//   count_o      : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      kanata_id_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      instr_o,
    output logic [31:0]      kanata_id_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] count_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Storage; contents are never cleared, validity comes from the pointers.
    logic [31:0] pc_mem_r    [DEPTH];
    logic [31:0] instr_mem_r [DEPTH];
    logic [31:0] id_mem_r    [DEPTH];

    // Pointers carry one extra wrap bit above the index.
    logic [IDX_W:0]   wr_ptr_r;
    logic [IDX_W:0]   rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic empty_s;
    logic full_s;
    logic push_s;
    logic pop_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]) &&
                     (wr_ptr_r[IDX_W] != rd_ptr_r[IDX_W]);

    // Full is judged before any same-cycle pop, so a full buffer refuses
    // a push even while decode drains it.
    assign ready_o = ~full_s;
    assign valid_o = ~empty_s;
    assign count_o = count_r;

    assign push_s = valid_i & ready_o & ~flush_i;
    assign pop_s  = valid_o & ready_i & ~flush_i;

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_r <= {(IDX_W+1){1'b0}};
            rd_ptr_r <= {(IDX_W+1){1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {(IDX_W+1){1'b0}};
            rd_ptr_r <= {(IDX_W+1){1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry write on push.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r[IDX_W-1:0]]    <= pc_i;
            instr_mem_r[wr_ptr_r[IDX_W-1:0]] <= instr_i;
            id_mem_r[wr_ptr_r[IDX_W-1:0]]    <= kanata_id_i;
        end
    end

    // Head presentation, forced to zero while empty.
    always_comb begin
        pc_o        = 32'h0000_0000;
        instr_o     = 32'h0000_0000;
        kanata_id_o = 32'h0000_0000;
        if (valid_o) begin
            pc_o        = pc_mem_r[rd_ptr_r[IDX_W-1:0]];
            instr_o     = instr_mem_r[rd_ptr_r[IDX_W-1:0]];
            kanata_id_o = id_mem_r[rd_ptr_r[IDX_W-1:0]];
        end else begin
            pc_o        = 32'h0000_0000;
            instr_o     = 32'h0000_0000;
            kanata_id_o = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_buffer
//   Directed bench for fetch_buffer (DEPTH=4). Inputs change 1 time unit after
//   the rising edge; outputs are compared at the same point, away from the
//   edge. All comparisons go through check_val.
// -----------------------------------------------------------------------------
module tb_fetch_buffer;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        flush_i;
    logic        valid_i;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic [31:0] kanata_id_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic [31:0] kanata_id_o;
    logic        ready_i;
    logic [2:0]  count_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    fetch_buffer dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .pc_i        (pc_i),
        .instr_i     (instr_i),
        .kanata_id_i (kanata_id_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .pc_o        (pc_o),
        .instr_o     (instr_o),
        .kanata_id_o (kanata_id_o),
        .ready_i     (ready_i),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] id);
        valid_i     = 1'b1;
        pc_i        = pc;
        instr_i     = pc ^ 32'h5A5A_0000;
        kanata_id_i = id;
    endtask

    // Single accepted push; the buffer is expected to have room.
    task automatic do_push(input logic [31:0] pc, input logic [31:0] id);
        check_val("push_ready", {31'd0, ready_o}, 32'd1);
        present(pc, id);
        step();
        valid_i = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int out_exp;
        int in_id;
        int model_cnt;
        logic will_push;
        logic will_pop;

        rstn_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        pc_i = 32'd0; instr_i = 32'd0; kanata_id_i = 32'd0;
        #3;
        check_val("rst_valid", {31'd0, valid_o}, 32'd0);
        check_val("rst_ready", {31'd0, ready_o}, 32'd1);
        check_val("rst_count", {29'd0, count_o}, 32'd0);
        check_val("rst_pc", pc_o, 32'd0);
        check_val("rst_instr", instr_o, 32'd0);
        check_val("rst_id", kanata_id_o, 32'd0);
        #9 rstn_i = 1'b1;
        step();

        // 1: three pushes, decode stalled
        for (int i = 0; i < 3; i++) do_push(32'h8000_0000 + 32'(4 * i), 32'(i));
        check_val("t1_count", {29'd0, count_o}, 32'd3);
        check_val("t1_valid", {31'd0, valid_o}, 32'd1);
        check_val("t1_pc", pc_o, 32'h8000_0000);
        check_val("t1_instr", instr_o, 32'h8000_0000 ^ 32'h5A5A_0000);
        check_val("t1_id", kanata_id_o, 32'd0);
        check_val("t1_ready", {31'd0, ready_o}, 32'd1);

        // 2: fill, refuse 5th, then drain in order
        do_push(32'h8000_000C, 32'd3);
        check_val("t2_ready_full", {31'd0, ready_o}, 32'd0);
        check_val("t2_count_full", {29'd0, count_o}, 32'd4);
        present(32'h8000_0010, 32'd4);
        step();
        check_val("t2_count_refused", {29'd0, count_o}, 32'd4);
        ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_val("t2_valid", {31'd0, valid_o}, 32'd1);
            check_val("t2_pc", pc_o, 32'h8000_0000 + 32'(4 * k));
            check_val("t2_id", kanata_id_o, 32'(k));
            if (k == 0) check_val("t2_ready_k0", {31'd0, ready_o}, 32'd0);
            if (k == 1) check_val("t2_ready_k1", {31'd0, ready_o}, 32'd1);
            step();
            if (k == 1) valid_i = 1'b0;
            check_val("t2_count", {29'd0, count_o}, (k <= 1) ? 32'd3 : 32'(4 - k));
        end
        check_val("t2_empty", {31'd0, valid_o}, 32'd0);

        // 3: steady stream of 20, one entry in flight
        for (int n = 0; n <= 20; n++) begin
            if (n < 20) present(32'h9000_0000 + 32'(4 * n), 32'(100 + n));
            else        valid_i = 1'b0;
            if (n == 0) begin
                check_val("t3_valid0", {31'd0, valid_o}, 32'd0);
            end else begin
                check_val("t3_valid", {31'd0, valid_o}, 32'd1);
                check_val("t3_id", kanata_id_o, 32'(100 + n - 1));
                check_val("t3_count", {29'd0, count_o}, 32'd1);
                check_val("t3_ready", {31'd0, ready_o}, 32'd1);
            end
            step();
        end
        check_val("t3_count_end", {29'd0, count_o}, 32'd0);

        // 4: flush with two held entries and a push/pop in the same cycle
        ready_i = 1'b0;
        do_push(32'h8000_0000, 32'd200);
        do_push(32'h8000_0004, 32'd201);
        present(32'h8000_0008, 32'd202);
        flush_i = 1'b1; ready_i = 1'b1;
        step();
        flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        check_val("t4_valid", {31'd0, valid_o}, 32'd0);
        check_val("t4_count", {29'd0, count_o}, 32'd0);
        check_val("t4_ready", {31'd0, ready_o}, 32'd1);
        check_val("t4_pc", pc_o, 32'd0);
        do_push(32'h8000_0100, 32'd203);
        check_val("t4_new_pc", pc_o, 32'h8000_0100);
        check_val("t4_new_id", kanata_id_o, 32'd203);
        check_val("t4_new_count", {29'd0, count_o}, 32'd1);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        check_val("t4_drained", {31'd0, valid_o}, 32'd0);

        // 5: pointer wrap under random decode backpressure
        out_exp = 0; in_id = 0; model_cnt = 0;
        present(32'hB000_0000, 32'd0);
        for (int cyc = 0; cyc < 2000 && out_exp < 50; cyc++) begin
            ready_i = 1'($urandom_range(0, 1));
            check_val("t5_count", {29'd0, count_o}, 32'(model_cnt));
            check_val("t5_count_le4", {31'd0, (count_o > 3'd4)}, 32'd0);
            check_val("t5_ready", {31'd0, ready_o}, {31'd0, (model_cnt < 4)});
            check_val("t5_valid", {31'd0, valid_o}, {31'd0, (model_cnt > 0)});
            will_push = valid_i && (model_cnt < 4);
            will_pop  = (model_cnt > 0) && ready_i;
            if (will_pop) begin
                check_val("t5_id", kanata_id_o, 32'(out_exp));
                check_val("t5_pc", pc_o, 32'hB000_0000 + 32'(4 * out_exp));
                out_exp++;
            end
            step();
            model_cnt = model_cnt + (will_push ? 1 : 0) - (will_pop ? 1 : 0);
            if (will_push) begin
                in_id++;
                if (in_id < 50) present(32'hB000_0000 + 32'(4 * in_id), 32'(in_id));
                else            valid_i = 1'b0;
            end
        end
        check_val("t5_total", 32'(out_exp), 32'd50);
        ready_i = 1'b0;
        valid_i = 1'b0;

        // 6: asynchronous reset with entries held
        for (int i = 0; i < 3; i++) do_push(32'hC000_0000 + 32'(4 * i), 32'(300 + i));
        check_val("t6_count_pre", {29'd0, count_o}, 32'd3);
        #2 rstn_i = 1'b0;
        #1;
        check_val("t6_valid", {31'd0, valid_o}, 32'd0);
        check_val("t6_count", {29'd0, count_o}, 32'd0);
        check_val("t6_ready", {31'd0, ready_o}, 32'd1);
        check_val("t6_pc", pc_o, 32'd0);
        step();
        #2 rstn_i = 1'b1;
        step();
        do_push(32'h8000_0200, 32'd400);
        check_val("t6_post_valid", {31'd0, valid_o}, 32'd1);
        check_val("t6_post_pc", pc_o, 32'h8000_0200);
        check_val("t6_post_instr", instr_o, 32'h8000_0200 ^ 32'h5A5A_0000);
        check_val("t6_post_id", kanata_id_o, 32'd400);
        check_val("t6_post_count", {29'd0, count_o}, 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Captures fetched {pc, instruction, kanata id} triples with valid/ready handshakes on both sides. Presents them to decode in order, first-word fall-through.
- Drives fetch's stall through ready_o, which decouples icache miss latency from decode backpressure.
- Flushes completely on a taken branch.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of occupancy count

Ports:
clk_i  in  1  clock; all state updates on rising edge
rstn_i  in  1  asynchronous active-low reset
flush_i  in  1  taken branch/redirect; empties the buffer
valid_i  in  1  fetch presents a valid instruction
pc_i  in  32 (bus32_t)  PC of the presented instruction
instr_i  in  32 (instruction_t)  presented instruction
kanata_id_i  in  32 (int)  trace id of the presented instruction
ready_o  out  1  buffer accepts a push this cycle; fetch stall = ~ready_o
valid_o  out  1  head entry valid for decode
pc_o  out  32 (bus32_t)  head PC
instr_o  out  32 (instruction_t)  head instruction
kanata_id_o  out  32 (int)  head trace id
ready_i  in  1  decode consumes the head this cycle
count_o  out  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset is asynchronous, active-low, on rstn_i. It clears the pointers and the count.
- Reset values: valid_o=0, ready_o=1, count_o=0, pc_o=0, instr_o=0, kanata_id_o=0.
- Reset mid-operation discards all entries immediately.
- Storage: DEPTH-entry circular array.
- Pointers: wr_ptr and rd_ptr, each log2(DEPTH)+1 bits, with the extra bit as wrap flag.
  - empty when the pointers are equal.
  - full when the index bits are equal and the wrap bits differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- push = valid_i & ready_o & ~flush_i. On push, the entry is written at wr_ptr and wr_ptr increments.
- pop = valid_o & ready_i & ~flush_i. On pop, rd_ptr increments.
- ready_o = ~full. It is registered-state only; there is no combinational path from ready_i to ready_o.
  - A push into a full buffer is refused even if decode pops in the same cycle.
- valid_o = ~empty, from state only.
- pc_o, instr_o and kanata_id_o show the entry at rd_ptr when non-empty, and 0 when empty.
- Latency: an entry pushed in cycle N is visible on valid_o in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop on a non-empty, non-full buffer: count_o is unchanged and FIFO order is preserved.
- count_o = wr_ptr - rd_ptr, modulo 2*DEPTH. It is updated every cycle by +push -pop.
- Flush: when flush_i=1 at a rising edge, wr_ptr and rd_ptr are both set to 0.
  - Any push and any pop in that cycle are suppressed.
  - Next cycle: valid_o=0, count_o=0, ready_o=1.
  - The fetch input in the flush cycle belongs to the wrong path and is dropped.
  - Fetch loads new_pc on the same edge, so the first post-flush instruction arrives the following cycle or later.
- Flush while empty has no visible effect beyond holding the empty state.
- Entry contents are not cleared on flush or pop; only the pointers define validity.
- No assertion of valid_o without a prior push since the last reset or flush.
- valid_i with ready_o=0: the buffer holds no commitment. Fetch holds its PC because stall_i=1, and re-presents the instruction.
- Handshake rules: valid_i and its data may change only when a push occurred or flush_i=1. Decode may deassert ready_i at any time.

Test Plan:
1. Reset, then push 3 entries (pc 0x80000000/04/08, ids 0/1/2) with ready_i=0 -> count_o=3, valid_o=1, pc_o=0x80000000, kanata_id_o=0, ready_o=1.
2. Fill to DEPTH=4 with ready_i=0 -> ready_o=0 after the 4th push. A 5th valid_i (pc 0x80000010) is not accepted and count_o stays 4. Then set ready_i=1 -> entries drain in order 0x80000000..0x8000000C, and 0x80000010 is accepted one cycle after the first pop.
3. Steady stream with ready_i=1 and valid_i=1 every cycle, 20 instructions -> exactly 20 pops in push order, count_o stays 1 after the first cycle, ready_o never drops, no bubbles after the first cycle.
4. With 2 entries held, assert flush_i together with valid_i=1 (pc 0x80000008) and ready_i=1 -> next cycle valid_o=0, count_o=0, and neither the flushed entries nor 0x80000008 ever appear. The next push (pc 0x80000100) is the first output.
5. Pointer wrap: ready_i toggled 1/0 pseudo-randomly for 50 pushes with incrementing ids -> output id sequence is 0..49 with no gaps or duplicates, and count_o never exceeds 4.
6. Deassert rstn_i asynchronously (between edges) with 3 entries held -> valid_o=0, count_o=0 and ready_o=1 immediately, before the next clock edge. After release, the first push is output correctly.
